// File: rtl/snell_numerator.sv
// Sequential shift-add multiplier forming n1*sin(theta1) in unsigned Q(WIDTH-FRAC).FRAC, saturating on overflow.
// Optional round-half-up before saturation when SNELL_NUM_ROUND_EN is defined; latency is WIDTH+1 cycles either way.
module snell_numerator #(
  parameter int WIDTH = 13,
  parameter int FRAC  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] sin_t1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIN
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     product_q, product_d;
  logic                 ovf_q, ovf_d;

  logic [2*WIDTH:0]     full_adj;
  logic [2*WIDTH:0]     scaled;
  logic                 sat;

  // One extra bit keeps the rounding carry visible to the saturation test.
`ifdef SNELL_NUM_ROUND_EN
  localparam logic [2*WIDTH:0] HALF = (2*WIDTH+1)'(1) << (FRAC - 1);
  assign full_adj = {1'b0, acc_q} + HALF;
`else
  assign full_adj = {1'b0, acc_q};
`endif

  assign scaled = full_adj >> FRAC;
  assign sat    = |scaled[2*WIDTH:WIDTH];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, n1};
          mplier_d = sin_t1;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = MUL;
        end
      end
      MUL: begin
        // LSB-first over the latched multiplier; multiplicand walks left.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIN;
      end
      FIN: begin
        product_d = sat ? MAX : scaled[WIDTH-1:0];
        ovf_d     = sat;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_snell_numerator.sv
// Directed vectors and multi-cycle corner sequences for snell_numerator (default or SNELL_NUM_ROUND_EN build).
module tb_snell_numerator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [12:0] n1 = '0;
  logic [12:0] sin_t1 = '0;
  logic        busy, done, ovf;
  logic [12:0] product;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  snell_numerator #(.WIDTH(13), .FRAC(12)) dut (
    .clk(clk), .rst(rst), .start(start), .n1(n1), .sin_t1(sin_t1),
    .busy(busy), .done(done), .product(product), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    a;
    int    b;
    int    exp_p;
    int    exp_o;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input int a, input int b, input int ep, input int eo);
    int lat;
    bit got;
    @(negedge clk);
    n1 = 13'(a); sin_t1 = 13'(b); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, " busy_after_start"}, int'(busy), 1);
    lat = 0; got = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; got = 1; break; end
    end
    chk({name, " latency"}, lat, 14);
    if (got) begin
      chk({name, " product"}, int'(product), ep);
      chk({name, " ovf"}, int'(ovf), eo);
      chk({name, " busy_at_done"}, int'(busy), 0);
      @(posedge clk); #1;
      chk({name, " done_one_cycle"}, int'(done), 0);
    end
  endtask

  initial begin
    int dones, p4, o4, t[3];
    bit got;

    vecs[0] = '{"t1_1p5x0p5",   6144, 2048, 3072, 0};
    vecs[1] = '{"t2_max_sat",   8191, 8191, 8191, 1};
    vecs[2] = '{"zero_n1",         0, 4096,    0, 0};
    vecs[3] = '{"one_x_one",    4096, 4096, 4096, 0};
    vecs[4] = '{"max_x_one",    8191, 4096, 8191, 0};
    vecs[5] = '{"just_over",    8191, 4097, 8191, 1};
`ifdef SNELL_NUM_ROUND_EN
    vecs[6] = '{"t3_half_up",   4097, 2049, 2050, 0};
    vecs[7] = '{"mid_round",    3000, 1234,  904, 0};
    vecs[8] = '{"half_lsb",     2048,    1,    1, 0};
    vecs[9] = '{"round_to_sat", 5791, 5794, 8191, 1};
`else
    vecs[6] = '{"t3_half_up",   4097, 2049, 2049, 0};
    vecs[7] = '{"mid_round",    3000, 1234,  903, 0};
    vecs[8] = '{"half_lsb",     2048,    1,    0, 0};
    vecs[9] = '{"round_to_sat", 5791, 5794, 8191, 0};
`endif

    // Reset values while rst is held
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst product", int'(product), 0);
    chk("rst ovf", int'(ovf), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp_p, vecs[i].exp_o);

    // start toggled while busy, operands changed mid-operation
    @(negedge clk);
    n1 = 13'd6144; sin_t1 = 13'd2048; start = 1'b1;
    @(posedge clk); #1;
    dones = 0; p4 = -1; o4 = -1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      start = (i <= 12) ? i[0] : 1'b0;
      if (i == 5) begin n1 = 13'd8191; sin_t1 = 13'd8191; end
      @(posedge clk); #1;
      if (done) begin dones++; p4 = int'(product); o4 = int'(ovf); end
    end
    start = 1'b0;
    chk("t4 done_count", dones, 1);
    chk("t4 product", p4, 3072);
    chk("t4 ovf", o4, 0);

    // reset mid-operation (product currently 3072)
    @(negedge clk);
    n1 = 13'd4096; sin_t1 = 13'd4096; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5 busy", int'(busy), 0);
    chk("t5 done", int'(done), 0);
    chk("t5 product", int'(product), 0);
    chk("t5 ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("t5 no_done", dones, 0);
    run_op("t5_after", 4096, 4096, 4096, 0);

    // start held high: back-to-back operations
    @(negedge clk);
    n1 = 13'd4096; sin_t1 = 13'd1000; start = 1'b1;
    for (int d = 0; d < 3; d++) begin
      got = 0; t[d] = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (done) begin got = 1; break; end
      end
      chk("t6 done_seen", int'(got), 1);
      t[d] = cyc;
      chk("t6 product", int'(product), 1000);
    end
    start = 1'b0;
    chk("t6 period_a", t[1] - t[0], 15);
    chk("t6 period_b", t[2] - t[1], 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
